// File: rtl/duty_sequencer.sv
// Duty-cycle sequencer: on each counter wrap, loads the next duty table entry
// and writes it to compare1 over a regs bus shared with the host, host first.
module duty_sequencer #(
   parameter logic [5:0] CMP_LO_ADDR = 6'h0C,
   parameter logic [5:0] CMP_HI_ADDR = 6'h0D
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        h_read,
   input  logic        h_write,
   input  logic [5:0]  h_addr,
   input  logic [7:0]  h_data_write,
   output logic [7:0]  h_data_read,
   output logic        read,
   output logic        write,
   output logic [5:0]  addr,
   output logic [7:0]  data_write,
   input  logic [7:0]  data_read,
   input  logic [15:0] count_val,
   input  logic [15:0] period,
   input  logic        seq_en,
   input  logic [1:0]  seq_len,
   input  logic        tbl_we,
   input  logic [1:0]  tbl_idx,
   input  logic [15:0] tbl_data,
   output logic [1:0]  seq_idx,
   output logic        busy,
   output logic        missed
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_tbl [4];
   logic [15:0] r_prev_cnt;
   logic [15:0] r_entry;
   logic [1:0]  r_seq_idx;
   logic        r_pend;
   logic        r_missed;

   logic        w_host;
   logic        w_wrap;
   logic        w_idle;
   logic        w_start;
   logic        w_hi_done;
   logic [1:0]  w_next_idx;

   assign w_host  = h_read | h_write;
   // A wrap is either an up-count rollover (period->0) or a down-count reload (0->period).
   assign w_wrap  = (period != 16'd0) &&
                    (((r_prev_cnt == period) && (count_val == 16'd0)) ||
                     ((r_prev_cnt == 16'd0) && (count_val == period)));
   assign w_idle    = (r_state == ST_IDLE);
   assign w_start   = w_idle && seq_en && (w_wrap || r_pend);
   assign w_hi_done = (r_state == ST_WR_HI) && !w_host;

   assign h_data_read = data_read;
   assign seq_idx     = r_seq_idx;
   assign busy        = !w_idle;
   assign missed      = r_missed;

   // Next table index; an out-of-range index or a disabled sequencer restarts at 0.
   always_comb begin
      w_next_idx = 2'd0;
      if (!seq_en) begin
         w_next_idx = 2'd0;
      end else if (r_seq_idx >= seq_len) begin
         w_next_idx = 2'd0;
      end else begin
         w_next_idx = r_seq_idx + 2'd1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; any host strobe stalls the write states.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_WR_LO;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WR_LO: begin
            if (w_host) begin
               w_state_nxt = ST_WR_LO;
            end else begin
               w_state_nxt = ST_WR_HI;
            end
         end
         ST_WR_HI: begin
            if (w_host) begin
               w_state_nxt = ST_WR_HI;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bus outputs: host passthrough wins, otherwise one compare byte per write state.
   always_comb begin
      read       = 1'b0;
      write      = 1'b0;
      addr       = 6'd0;
      data_write = 8'd0;
      if (w_host) begin
         read       = h_read;
         write      = h_write;
         addr       = h_addr;
         data_write = h_data_write;
      end else begin
         case (r_state)
            ST_WR_LO: begin
               write      = 1'b1;
               addr       = CMP_LO_ADDR;
               data_write = r_entry[7:0];
            end
            ST_WR_HI: begin
               write      = 1'b1;
               addr       = CMP_HI_ADDR;
               data_write = r_entry[15:8];
            end
            default: begin
               write      = 1'b0;
               addr       = 6'd0;
               data_write = 8'd0;
            end
         endcase
      end
   end

   // Duty table write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_tbl[i] <= 16'd0;
         end
      end else if (tbl_we) begin
         r_tbl[tbl_idx] <= tbl_data;
      end else begin
         r_tbl[tbl_idx] <= r_tbl[tbl_idx];
      end
   end

   // Previous counter sample and latched entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_cnt <= 16'd0;
         r_entry    <= 16'd0;
      end else begin
         r_prev_cnt <= count_val;
         if (w_start) begin
            r_entry <= r_tbl[r_seq_idx];
         end else begin
            r_entry <= r_entry;
         end
      end
   end

   // Table index: held at 0 while disabled in IDLE, advanced on HI write completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_idx <= 2'd0;
      end else if (w_idle && !seq_en) begin
         r_seq_idx <= 2'd0;
      end else if (w_hi_done) begin
         r_seq_idx <= w_next_idx;
      end else begin
         r_seq_idx <= r_seq_idx;
      end
   end

   // One-deep pending event; a second unserviced event raises the sticky missed flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend   <= 1'b0;
         r_missed <= 1'b0;
      end else if (!seq_en) begin
         r_pend   <= 1'b0;
         r_missed <= r_missed;
      end else if (w_idle) begin
         r_pend   <= 1'b0;
         r_missed <= r_missed;
      end else if (w_wrap) begin
         r_pend   <= 1'b1;
         r_missed <= r_missed | r_pend;
      end else begin
         r_pend   <= r_pend;
         r_missed <= r_missed;
      end
   end

endmodule

// File: tb/tb_duty_sequencer.sv
// Directed self-checking bench for duty_sequencer.
module tb_duty_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        h_read, h_write;
   logic [5:0]  h_addr;
   logic [7:0]  h_data_write, h_data_read;
   logic        read, write;
   logic [5:0]  addr;
   logic [7:0]  data_write, data_read;
   logic [15:0] count_val, period;
   logic        seq_en;
   logic [1:0]  seq_len;
   logic        tbl_we;
   logic [1:0]  tbl_idx;
   logic [15:0] tbl_data;
   logic [1:0]  seq_idx;
   logic        busy, missed;

   int total = 0;
   int bad   = 0;

   duty_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .h_read(h_read), .h_write(h_write), .h_addr(h_addr),
      .h_data_write(h_data_write), .h_data_read(h_data_read),
      .read(read), .write(write), .addr(addr),
      .data_write(data_write), .data_read(data_read),
      .count_val(count_val), .period(period),
      .seq_en(seq_en), .seq_len(seq_len),
      .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
      .seq_idx(seq_idx), .busy(busy), .missed(missed)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge, apply a counter value, settle.
   task automatic cyc(input logic [15:0] c);
      @(negedge clk);
      count_val = c;
      #1;
   endtask

   task automatic tbl_wr(input logic [1:0] i, input logic [15:0] d);
      @(negedge clk);
      tbl_we = 1'b1; tbl_idx = i; tbl_data = d;
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      h_read = 1'b0; h_write = 1'b0; h_addr = 6'd0; h_data_write = 8'd0;
      data_read = 8'h3C; count_val = 16'd5; period = 16'd10;
      seq_en = 1'b0; seq_len = 2'd0; tbl_we = 1'b0; tbl_idx = 2'd0; tbl_data = 16'd0;
      #12;
      total++;
      if ({busy, missed, seq_idx} !== 4'b0000) begin
         bad++; $display("FAIL reset_state got=%b exp=0000", {busy, missed, seq_idx});
      end
      total++;
      if ({read, write, addr, data_write} !== 16'h0000) begin
         bad++; $display("FAIL reset_bus_idle got=%h exp=0000", {read, write, addr, data_write});
      end
      h_write = 1'b1; h_addr = 6'h05; h_data_write = 8'h55;
      #1;
      total++;
      if ({read, write, addr, data_write} !== {1'b0, 1'b1, 6'h05, 8'h55}) begin
         bad++; $display("FAIL reset_host_pass got=%h exp=%h", {read, write, addr, data_write}, {1'b0, 1'b1, 6'h05, 8'h55});
      end
      total++;
      if (h_data_read !== 8'h3C) begin
         bad++; $display("FAIL reset_rdata got=%h exp=3c", h_data_read);
      end
      h_write = 1'b0; h_addr = 6'd0; h_data_write = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(16'd5);
   endtask

   task automatic test_single;
      tbl_wr(2'd0, 16'h1234);
      seq_en = 1'b1;
      cyc(16'd10);
      cyc(16'd0);
      total++;
      if ({busy, write} !== 2'b00) begin
         bad++; $display("FAIL single_event_cycle got=%b exp=00", {busy, write});
      end
      cyc(16'd1);
      total++;
      if ({read, write, addr, data_write} !== {1'b0, 1'b1, 6'h0C, 8'h34}) begin
         bad++; $display("FAIL single_lo got=%h exp=%h", {read, write, addr, data_write}, {1'b0, 1'b1, 6'h0C, 8'h34});
      end
      cyc(16'd2);
      total++;
      if ({read, write, addr, data_write} !== {1'b0, 1'b1, 6'h0D, 8'h12}) begin
         bad++; $display("FAIL single_hi got=%h exp=%h", {read, write, addr, data_write}, {1'b0, 1'b1, 6'h0D, 8'h12});
      end
      cyc(16'd5);
      total++;
      if ({busy, write, seq_idx} !== 4'b0000) begin
         bad++; $display("FAIL single_after got=%b exp=0000", {busy, write, seq_idx});
      end
      cyc(16'd5);
      total++;
      if ({busy, write} !== 2'b00) begin
         bad++; $display("FAIL single_no_repeat got=%b exp=00", {busy, write});
      end
   endtask

   task automatic test_multi;
      logic [7:0] exp_lo [4];
      logic [1:0] exp_ix [4];
      exp_lo = '{8'h01, 8'h02, 8'h03, 8'h01};
      exp_ix = '{2'd1, 2'd2, 2'd0, 2'd1};
      tbl_wr(2'd0, 16'h0001);
      tbl_wr(2'd1, 16'h0002);
      tbl_wr(2'd2, 16'h0003);
      seq_len = 2'd2;
      for (int k = 0; k < 4; k++) begin
         cyc(16'd10);
         cyc(16'd0);
         cyc(16'd1);
         total++;
         if ({write, addr, data_write} !== {1'b1, 6'h0C, exp_lo[k]}) begin
            bad++; $display("FAIL multi_lo[%0d] got=%h exp=%h", k, {write, addr, data_write}, {1'b1, 6'h0C, exp_lo[k]});
         end
         cyc(16'd2);
         total++;
         if ({write, addr, data_write} !== {1'b1, 6'h0D, 8'h00}) begin
            bad++; $display("FAIL multi_hi[%0d] got=%h exp=%h", k, {write, addr, data_write}, {1'b1, 6'h0D, 8'h00});
         end
         cyc(16'd5);
         total++;
         if (seq_idx !== exp_ix[k]) begin
            bad++; $display("FAIL multi_idx[%0d] got=%0d exp=%0d", k, seq_idx, exp_ix[k]);
         end
      end
   endtask

   task automatic test_host;
      tbl_wr(2'd1, 16'hBEEF);
      tbl_wr(2'd0, 16'h1234);
      seq_len = 2'd0;
      cyc(16'd10);
      cyc(16'd0);
      for (int k = 0; k < 2; k++) begin
         cyc(16'd1);
         h_write = 1'b1; h_addr = 6'h02; h_data_write = 8'hAA; data_read = 8'h71;
         #1;
         total++;
         if ({busy, read, write, addr, data_write, h_data_read} !== {1'b1, 1'b0, 1'b1, 6'h02, 8'hAA, 8'h71}) begin
            bad++; $display("FAIL host_hold[%0d] got=%h exp=%h", k, {busy, read, write, addr, data_write, h_data_read}, {1'b1, 1'b0, 1'b1, 6'h02, 8'hAA, 8'h71});
         end
      end
      cyc(16'd1);
      h_write = 1'b0; h_addr = 6'd0; h_data_write = 8'd0;
      #1;
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0C, 8'hEF}) begin
         bad++; $display("FAIL host_lo_late got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0C, 8'hEF});
      end
      cyc(16'd2);
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0D, 8'hBE}) begin
         bad++; $display("FAIL host_hi_late got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0D, 8'hBE});
      end
      cyc(16'd5);
      total++;
      if ({busy, seq_idx} !== 3'b000) begin
         bad++; $display("FAIL host_idx_wrap got=%b exp=000", {busy, seq_idx});
      end
   endtask

   task automatic test_pend;
      cyc(16'd10);
      cyc(16'd0);
      cyc(16'd10);
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0C, 8'h34}) begin
         bad++; $display("FAIL pend_lo1 got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0C, 8'h34});
      end
      cyc(16'd0);
      total++;
      if ({missed, write, addr, data_write} !== {1'b0, 1'b1, 6'h0D, 8'h12}) begin
         bad++; $display("FAIL pend_hi1 got=%h exp=%h", {missed, write, addr, data_write}, {1'b0, 1'b1, 6'h0D, 8'h12});
      end
      cyc(16'd5);
      total++;
      if ({missed, busy, write} !== 3'b100) begin
         bad++; $display("FAIL pend_missed got=%b exp=100", {missed, busy, write});
      end
      cyc(16'd5);
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0C, 8'h34}) begin
         bad++; $display("FAIL pend_lo2 got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0C, 8'h34});
      end
      cyc(16'd5);
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0D, 8'h12}) begin
         bad++; $display("FAIL pend_hi2 got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0D, 8'h12});
      end
      cyc(16'd5);
      cyc(16'd5);
      total++;
      if ({busy, write, missed} !== 3'b001) begin
         bad++; $display("FAIL pend_one_deep got=%b exp=001", {busy, write, missed});
      end
   endtask

   task automatic test_seq_en_drop;
      seq_len = 2'd2;
      cyc(16'd10);
      cyc(16'd0);
      cyc(16'd1);
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0C, 8'h34}) begin
         bad++; $display("FAIL drop_lo got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0C, 8'h34});
      end
      cyc(16'd2);
      seq_en = 1'b0;
      #1;
      total++;
      if ({write, addr, data_write} !== {1'b1, 6'h0D, 8'h12}) begin
         bad++; $display("FAIL drop_hi got=%h exp=%h", {write, addr, data_write}, {1'b1, 6'h0D, 8'h12});
      end
      cyc(16'd5);
      total++;
      if ({busy, seq_idx} !== 3'b000) begin
         bad++; $display("FAIL drop_idle got=%b exp=000", {busy, seq_idx});
      end
      cyc(16'd10);
      cyc(16'd0);
      cyc(16'd1);
      total++;
      if ({busy, write} !== 2'b00) begin
         bad++; $display("FAIL drop_ignored got=%b exp=00", {busy, write});
      end
      seq_en = 1'b1;
      seq_len = 2'd0;
      cyc(16'd5);
   endtask

   task automatic test_reset_mid;
      logic [15:0] pv [6];
      pv = '{16'd5, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0};
      cyc(16'd10);
      cyc(16'd0);
      cyc(16'd1);
      total++;
      if ({busy, missed} !== 2'b11) begin
         bad++; $display("FAIL rmid_before got=%b exp=11", {busy, missed});
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, missed, write} !== 3'b000) begin
         bad++; $display("FAIL rmid_async got=%b exp=000", {busy, missed, write});
      end
      cyc(16'd2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(16'd3 + 16'(k));
         total++;
         if ({busy, write} !== 2'b00) begin
            bad++; $display("FAIL rmid_no_write[%0d] got=%b exp=00", k, {busy, write});
         end
      end
      period = 16'd0;
      for (int k = 0; k < 6; k++) begin
         cyc(pv[k]);
         total++;
         if ({busy, write} !== 2'b00) begin
            bad++; $display("FAIL period0[%0d] got=%b exp=00", k, {busy, write});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_host();
      test_pend();
      test_seq_en_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
